fifo_rd_sched: RTL and testbench

//  Read-side scheduler for the async FIFO. Shares the FIFO read port among N_REQ

---
 rtl/fifo_rd_sched_pkg.sv | 21 ++
 rtl/fifo_rd_sched_if.sv | 28 ++
 rtl/fifo_rd_sched_rr_arbiter.sv | 33 +++
 rtl/fifo_rd_sched.sv | 133 +++++++++++++
 tb/tb_fifo_rd_sched.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_sched_pkg.sv
// Shared types and helpers for the FIFO read-side scheduler.
package fifo_rd_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam int MAX_REQ = 32;

    function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int n_req);
        logic [MAX_REQ-1:0] v;
        v = '0;
        if (idx >= 0 && idx < n_req && idx < MAX_REQ) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/fifo_rd_sched_if.sv
// Bundle of FIFO read-port, requester and response signals around the scheduler.
interface fifo_rd_sched_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 4,
    parameter int LEN_W      = 4
);
    logic [DATA_WIDTH-1:0]  fifo_data_out;
    logic                   fifo_empty;
    logic                   fifo_rd_en;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*LEN_W-1:0] req_len;
    logic [N_REQ-1:0]       gnt;
    logic                   rsp_valid;
    logic [DATA_WIDTH-1:0]  rsp_data;
    logic                   rsp_last;
    logic                   busy;
    logic                   timeout;

    modport master (
        input  fifo_data_out, fifo_empty, req, req_len,
        output fifo_rd_en, gnt, rsp_valid, rsp_data, rsp_last, busy, timeout
    );

    modport slave (
        output fifo_data_out, fifo_empty, req, req_len,
        input  fifo_rd_en, gnt, rsp_valid, rsp_data, rsp_last, busy, timeout
    );
endinterface

// File: rtl/fifo_rd_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping around.
module rr_arbiter
    import fifo_rd_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt_nxt,
    output logic [$clog2(N)-1:0] sel
);
    localparam int IDX_W = $clog2(N);

    logic               found;
    int                 idx;
    logic [MAX_REQ-1:0] oh;

    always_comb begin
        found = 1'b0;
        idx   = 0;
        sel   = ptr;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = IDX_W'(idx);
            end
        end
        oh      = onehot(int'(sel), N);
        gnt_nxt = found ? oh[N-1:0] : '0;
    end

endmodule

// File: rtl/fifo_rd_sched.sv
// Read-side scheduler: round-robin grants FIFO read bursts to N_REQ requesters.
// Define FIFO_RD_SCHED_TIMEOUT_EN to abort bursts stalled on an empty FIFO.
module fifo_rd_sched
    import fifo_rd_sched_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int N_REQ       = 4,
    parameter int LEN_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input logic             clk,
    input logic             rst_n,
    fifo_rd_sched_if.master bus
);
    localparam int             IDX_W = $clog2(N_REQ);
    localparam logic [LEN_W:0] ONE   = (LEN_W + 1)'(1);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d, arb_gnt;
    logic [IDX_W-1:0] ptr_q, ptr_d, arb_sel;
    logic [LEN_W:0]   pops_left_q, pops_left_d;
    logic [LEN_W-1:0] len_sel;
    logic             rd_en, rsp_valid_q, rsp_last_q, abort;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req     (bus.req),
        .ptr     (ptr_q),
        .gnt_nxt (arb_gnt),
        .sel     (arb_sel)
    );

    assign len_sel = bus.req_len[int'(arb_sel)*LEN_W +: LEN_W];
    assign rd_en   = (state_q == BURST) && !bus.fifo_empty && (pops_left_q != '0);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        pops_left_d = pops_left_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d     = BURST;
                    gnt_d       = arb_gnt;
                    ptr_d       = arb_sel;
                    pops_left_d = {1'b0, len_sel} + ONE;
                end
            end
            BURST: begin
                if (rd_en) begin
                    pops_left_d = pops_left_q - ONE;
                    if (pops_left_q == ONE) begin
                        state_d = WAIT;
                    end
                end else if (abort) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    pops_left_d = '0;
                end
            end
            WAIT: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // The response strobes are rd_en delayed one cycle to line up with the FIFO read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            ptr_q       <= IDX_W'(N_REQ - 1);
            pops_left_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            pops_left_q <= pops_left_d;
            rsp_valid_q <= rd_en;
            rsp_last_q  <= rd_en && (pops_left_q == ONE);
        end
    end

`ifdef FIFO_RD_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
    logic            timeout_q;

    // Counts consecutive empty cycles inside a burst; any pop restarts the count.
    always_comb begin
        idle_cnt_d = '0;
        abort      = 1'b0;
        if (state_q == BURST && bus.fifo_empty) begin
            if (idle_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                abort = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= abort;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign abort       = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.fifo_rd_en = rd_en;
    assign bus.gnt        = gnt_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_valid_q ? bus.fifo_data_out : '0;
    assign bus.rsp_last   = rsp_last_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Directed scoreboard bench for fifo_rd_sched with a behavioural FIFO on the read port.
// Covers the FIFO_RD_SCHED_TIMEOUT_EN build as well as the default build.
module tb_fifo_rd_sched;

    localparam int DW         = 8;
    localparam int NR         = 4;
    localparam int LW         = 4;
    localparam int TB_TIMEOUT = 16;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic [3:0] gnt;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       fifo_flush;
    logic [7:0] mem [256];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];

    fifo_rd_sched_if #(.DATA_WIDTH(DW), .N_REQ(NR), .LEN_W(LW)) bus ();

    fifo_rd_sched #(
        .DATA_WIDTH  (DW),
        .N_REQ       (NR),
        .LEN_W       (LW),
        .TIMEOUT_CYC (TB_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO: data appears one cycle after the pop strobe.
    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (bus.fifo_rd_en) begin
            bus.fifo_data_out <= mem[rd_ptr % 256];
            rd_ptr            <= rd_ptr + 1;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [15:0] lens);
        bus.req     = r;
        bus.req_len = lens;
    endtask

    task automatic expectWord(input int d, input bit last, input int g);
        exp_t e;
        e.data = 8'(d);
        e.last = last;
        e.gnt  = 4'(g);
        exp_q.push_back(e);
    endtask

    task automatic pushWords(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 256] = 8'(base + i);
            wr_ptr++;
        end
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        applyStimulus(4'b0000, 16'h0000);
        fifo_flush = 1'b1;
        repeat (2) @(negedge clk);
        fifo_flush = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, int'(bus.busy), 0);
    endtask

    // Pops the expected response for every presented word.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_unexpected: got data %0h, expected no word at %0t",
                             bus.rsp_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sb_data", int'(bus.rsp_data), int'(e.data));
                    checkOutput("sb_last", int'(bus.rsp_last), int'(e.last));
                    checkOutput("sb_gnt", int'(bus.gnt), int'(e.gnt));
                end
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        fifo_flush = 1'b0;
        applyStimulus(4'b0000, 16'h0000);
        fork
            monitor();
        join_none

        $display("[TB] reset values");
        resetDut();
        checkOutput("rst_gnt", int'(bus.gnt), 0);
        checkOutput("rst_rd_en", int'(bus.fifo_rd_en), 0);
        checkOutput("rst_rsp_valid", int'(bus.rsp_valid), 0);
        checkOutput("rst_rsp_data", int'(bus.rsp_data), 0);
        checkOutput("rst_rsp_last", int'(bus.rsp_last), 0);
        checkOutput("rst_busy", int'(bus.busy), 0);
        checkOutput("rst_timeout", int'(bus.timeout), 0);

        $display("[TB] single 4-word burst for requester 0");
        pushWords(8'h10, 8);
        applyStimulus(4'b0001, 16'h3333);
        for (int i = 0; i < 4; i++) expectWord(8'h10 + i, i == 3, 4'b0001);
        @(negedge clk);
        checkOutput("t1_gnt", int'(bus.gnt), 4'b0001);
        checkOutput("t1_busy", int'(bus.busy), 1);
        checkOutput("t1_rd_en", int'(bus.fifo_rd_en), 1);
        applyStimulus(4'b0000, 16'h3333);
        repeat (4) @(negedge clk);
        checkOutput("t1_gnt_held_last", int'(bus.gnt), 4'b0001);
        checkOutput("t1_last", int'(bus.rsp_last), 1);
        @(negedge clk);
        checkOutput("t1_gnt_drop", int'(bus.gnt), 0);
        checkOutput("t1_idle", int'(bus.busy), 0);
        repeat (3) @(negedge clk);
        checkOutput("t1_fifo_left", wr_ptr - rd_ptr, 4);

        $display("[TB] all requesters, single-word bursts");
        resetDut();
        pushWords(8'h20, 8);
        applyStimulus(4'b1111, 16'h0000);
        expectWord(8'h20, 1'b1, 4'b0001);
        expectWord(8'h21, 1'b1, 4'b0010);
        expectWord(8'h22, 1'b1, 4'b0100);
        expectWord(8'h23, 1'b1, 4'b1000);
        expectWord(8'h24, 1'b1, 4'b0001);
        @(negedge clk);
        checkOutput("t2_gnt_r0", int'(bus.gnt), 4'b0001);
        repeat (2) @(negedge clk);
        checkOutput("t2_gap", int'(bus.gnt), 0);
        @(negedge clk);
        checkOutput("t2_gnt_r1", int'(bus.gnt), 4'b0010);
        repeat (3) @(negedge clk);
        checkOutput("t2_gnt_r2", int'(bus.gnt), 4'b0100);
        repeat (3) @(negedge clk);
        checkOutput("t2_gnt_r3", int'(bus.gnt), 4'b1000);
        repeat (3) @(negedge clk);
        checkOutput("t2_gnt_wrap", int'(bus.gnt), 4'b0001);
        applyStimulus(4'b0000, 16'h0000);
        waitIdle(10, "t2_idle");
        repeat (3) @(negedge clk);
        checkOutput("t2_fifo_left", wr_ptr - rd_ptr, 3);

        $display("[TB] burst stalled by empty FIFO");
        resetDut();
        pushWords(8'h30, 2);
        applyStimulus(4'b0001, 16'h7777);
        for (int i = 0; i < 8; i++) expectWord(8'h30 + i, i == 7, 4'b0001);
        @(negedge clk);
        applyStimulus(4'b0000, 16'h7777);
        repeat (4) @(negedge clk);
        checkOutput("t3_stall_rd_en", int'(bus.fifo_rd_en), 0);
        checkOutput("t3_stall_busy", int'(bus.busy), 1);
        checkOutput("t3_stall_gnt", int'(bus.gnt), 4'b0001);
        repeat (7) @(negedge clk);
        pushWords(8'h32, 6);
        waitIdle(40, "t3_idle");
        checkOutput("t3_fifo_left", wr_ptr - rd_ptr, 0);

        $display("[TB] reset in the middle of a burst");
        resetDut();
        pushWords(8'h40, 8);
        applyStimulus(4'b0001, 16'h3333);
        expectWord(8'h40, 1'b0, 4'b0001);
        @(negedge clk);
        checkOutput("t4_gnt", int'(bus.gnt), 4'b0001);
        applyStimulus(4'b0000, 16'h3333);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t4_rst_gnt", int'(bus.gnt), 0);
        checkOutput("t4_rst_rd_en", int'(bus.fifo_rd_en), 0);
        checkOutput("t4_rst_rsp_valid", int'(bus.rsp_valid), 0);
        checkOutput("t4_rst_rsp_data", int'(bus.rsp_data), 0);
        checkOutput("t4_rst_busy", int'(bus.busy), 0);
        @(negedge clk);
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
        rst_n = 1'b1;
        pushWords(8'h50, 4);
        applyStimulus(4'b0011, 16'h0000);
        expectWord(8'h50, 1'b1, 4'b0001);
        expectWord(8'h51, 1'b1, 4'b0010);
        @(negedge clk);
        checkOutput("t4_ptr_reset_gnt", int'(bus.gnt), 4'b0001);
        repeat (3) @(negedge clk);
        checkOutput("t4_second_gnt", int'(bus.gnt), 4'b0010);
        applyStimulus(4'b0000, 16'h0000);
        waitIdle(10, "t4_idle");

        $display("[TB] burst on a FIFO that runs dry");
        resetDut();
        pushWords(8'h60, 1);
        applyStimulus(4'b0001, 16'h3333);
        expectWord(8'h60, 1'b0, 4'b0001);
        @(negedge clk);
        applyStimulus(4'b0000, 16'h3333);
`ifdef FIFO_RD_SCHED_TIMEOUT_EN
        begin
            int n;
            n = 1;
            while (!bus.timeout && n < 40) begin
                @(negedge clk);
                n++;
            end
            checkOutput("t5_timeout_cycle", n, 18);
            checkOutput("t5_timeout_gnt", int'(bus.gnt), 0);
            checkOutput("t5_timeout_busy", int'(bus.busy), 0);
            @(negedge clk);
            checkOutput("t5_timeout_pulse", int'(bus.timeout), 0);
        end
`else
        repeat (99) @(negedge clk);
        checkOutput("t5_still_busy", int'(bus.busy), 1);
        checkOutput("t5_still_gnt", int'(bus.gnt), 4'b0001);
        checkOutput("t5_no_timeout", int'(bus.timeout), 0);
        checkOutput("t5_rd_en_low", int'(bus.fifo_rd_en), 0);
`endif

        $display("[TB] maximum-length burst");
        resetDut();
        pushWords(8'h70, 20);
        applyStimulus(4'b0100, 16'hFFFF);
        for (int i = 0; i < 16; i++) expectWord(8'h70 + i, i == 15, 4'b0100);
        @(negedge clk);
        checkOutput("t6_gnt", int'(bus.gnt), 4'b0100);
        applyStimulus(4'b0000, 16'hFFFF);
        waitIdle(40, "t6_idle");
        repeat (3) @(negedge clk);
        checkOutput("t6_fifo_left", wr_ptr - rd_ptr, 4);

        repeat (4) @(negedge clk);
        checkOutput("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
